// File: rtl/fml_pkg.sv
// Shared FML constants and arbiter FSM state encoding.
// Imported by the FML arbiter and its round-robin picker.
package fml_pkg;

  localparam int FML_DW    = 64;
  localparam int FML_SELW  = 8;
  localparam int FML_BURST = 4;

  localparam logic [1:0] FML_ST_IDLE  = 2'd0;
  localparam logic [1:0] FML_ST_GRANT = 2'd1;
  localparam logic [1:0] FML_ST_DATA  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = FML_ST_IDLE,
    ST_GRANT = FML_ST_GRANT,
    ST_DATA  = FML_ST_DATA
  } fml_state_e;

endpackage

// File: rtl/fml_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after last+1, wrapping.
// Zero latency, no backpressure; o_vld low when no request is pending.
module fml_rr_pick
  import fml_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);

  int              w_sum;
  logic [IW-1:0]   w_cand;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_sum  = 0;
    w_cand = '0;
    for (int k = N; k >= 1; k--) begin
      w_sum  = (int'(i_last) + k) % N;
      w_cand = IW'(w_sum);
      if (i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/fml_arb.sv
// Round-robin merge of NMASTERS FML masters onto one FML slave; grant held for a full burst.
// Request to fml_stb in 1 cycle; losers hold m_stb until their own one-cycle ack.
module fml_arb
  import fml_pkg::*;
#(
  parameter int adr_width = 30,
  parameter int NMASTERS  = 4,
  parameter int BURST     = FML_BURST
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [NMASTERS*adr_width-1:0] m_adr,
  input  logic [NMASTERS-1:0]           m_stb,
  input  logic [NMASTERS-1:0]           m_we,
  input  logic [NMASTERS*FML_SELW-1:0]  m_sel,
  input  logic [NMASTERS*FML_DW-1:0]    m_di,
  output logic [NMASTERS-1:0]           m_ack,
  output logic [FML_DW-1:0]             m_do,
  output logic [adr_width-1:0]          fml_adr,
  output logic                          fml_stb,
  output logic                          fml_we,
  output logic [FML_SELW-1:0]           fml_sel,
  output logic [FML_DW-1:0]             fml_di,
  input  logic                          fml_ack,
  input  logic [FML_DW-1:0]             fml_do
);

  localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST - 1);
  localparam logic [IW-1:0] LAST_RESET = IW'(NMASTERS - 1);

  fml_state_e      r_state;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_last;
  logic [BW-1:0]   r_beat;

  logic            w_pick_vld;
  logic [IW-1:0]   w_pick_idx;

  logic [adr_width-1:0] w_adr [NMASTERS];
  logic [FML_SELW-1:0]  w_sel [NMASTERS];
  logic [FML_DW-1:0]    w_di  [NMASTERS];

  for (genvar g = 0; g < NMASTERS; g++) begin : g_unpack
    assign w_adr[g] = m_adr[g*adr_width +: adr_width];
    assign w_sel[g] = m_sel[g*FML_SELW +: FML_SELW];
    assign w_di[g]  = m_di[g*FML_DW +: FML_DW];
  end

  fml_rr_pick #(
    .N  (NMASTERS),
    .IW (IW)
  ) u_pick (
    .i_req  (m_stb),
    .i_last (r_last),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= LAST_RESET;
      r_beat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_grant <= w_pick_idx;
            r_state <= ST_GRANT;
          end
        end
        // A master dropping m_stb here is a protocol error; we keep waiting on the same grant.
        ST_GRANT: begin
          if (fml_ack) begin
            r_last  <= r_grant;
            r_beat  <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_beat == LAST_BEAT) begin
            r_state <= ST_IDLE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Address/sel/data always follow the registered grant; only stb and ack are state-gated.
  assign fml_adr = w_adr[r_grant];
  assign fml_we  = m_we[r_grant];
  assign fml_sel = w_sel[r_grant];
  assign fml_di  = w_di[r_grant];
  assign fml_stb = (r_state == ST_GRANT) & m_stb[r_grant];
  assign m_do    = fml_do;

  always_comb begin
    m_ack = '0;
    if (r_state == ST_GRANT) begin
      m_ack[r_grant] = fml_ack;
    end
  end

endmodule

// File: tb/tb_fml_arb.sv
// Directed testbench for fml_arb: one task per scenario, hand-computed expectations.
module tb_fml_arb;
  import fml_pkg::*;

  localparam int AW = 30;
  localparam int NM = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [NM*AW-1:0] m_adr;
  logic [NM-1:0]    m_stb;
  logic [NM-1:0]    m_we;
  logic [NM*8-1:0]  m_sel;
  logic [NM*64-1:0] m_di;
  logic [NM-1:0]    m_ack;
  logic [63:0]      m_do;
  logic [AW-1:0]    fml_adr;
  logic             fml_stb;
  logic             fml_we;
  logic [7:0]       fml_sel;
  logic [63:0]      fml_di;
  logic             fml_ack;
  logic [63:0]      fml_do;

  int checks = 0;
  int errors = 0;
  int ack_cnt [NM];
  int overlap_cnt = 0;

  fml_arb #(.adr_width(AW), .NMASTERS(NM), .BURST(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_adr     (m_adr),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_sel     (m_sel),
    .m_di      (m_di),
    .m_ack     (m_ack),
    .m_do      (m_do),
    .fml_adr   (fml_adr),
    .fml_stb   (fml_stb),
    .fml_we    (fml_we),
    .fml_sel   (fml_sel),
    .fml_di    (fml_di),
    .fml_ack   (fml_ack),
    .fml_do    (fml_do)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    for (int i = 0; i < NM; i++) ack_cnt[i] = 0;
  end

  always @(negedge sys_clk) begin
    for (int i = 0; i < NM; i++) if (m_ack[i] === 1'b1) ack_cnt[i]++;
    if (!$onehot0(m_ack)) overlap_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge sys_clk); #1;
  endtask

  task automatic at_neg();
    @(negedge sys_clk);
  endtask

  task automatic init_inputs();
    sys_rst_n = 1'b0;
    m_stb = '0; m_we = '0; fml_ack = 1'b0; fml_do = '0;
    for (int i = 0; i < NM; i++) begin
      m_adr[i*AW +: AW] = AW'(32'h1000 * (i + 1));
      m_sel[i*8 +: 8]   = 8'hF0 | 8'(i);
      m_di[i*64 +: 64]  = 64'hDA7A_0000_0000_0000 | 64'(i);
    end
  endtask

  // Waits for fml_stb, acks one cycle later, returns the acked master, rides out DATA.
  task automatic serve(input bit drop, output int who);
    int n;
    who = -1;
    n = 0;
    at_neg();
    while (fml_stb !== 1'b1 && n < 20) begin
      cyc(); at_neg(); n++;
    end
    if (n >= 20) begin
      errors++; checks++;
      $display("FAIL serve_timeout: fml_stb=%b after %0d cycles, required 1", fml_stb, n);
      return;
    end
    cyc();
    fml_ack = 1'b1;
    at_neg();
    checks++;
    if (!$onehot(m_ack)) begin
      errors++;
      $display("FAIL serve_ack_onehot: m_ack=%b, required one-hot", m_ack);
    end
    for (int i = 0; i < NM; i++) if (m_ack[i]) who = i;
    cyc();
    fml_ack = 1'b0;
    if (drop && who >= 0) m_stb[who] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      checks++;
      if (dut.r_state !== ST_DATA) begin
        errors++;
        $display("FAIL serve_data_state: beat %0d state=%0d, required %0d", k, dut.r_state, ST_DATA);
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    init_inputs();
    m_stb = 4'hF; fml_ack = 1'b1;
    cyc(); cyc();
    at_neg();
    checks++;
    if (fml_stb !== 1'b0 || m_ack !== 4'b0) begin
      errors++; $display("FAIL reset_outputs: fml_stb=%b m_ack=%b, required 0 0000", fml_stb, m_ack);
    end
    checks++;
    if (dut.r_state !== ST_IDLE || dut.r_grant !== 2'd0 || dut.r_last !== 2'd3 || dut.r_beat !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs: state=%0d grant=%0d last=%0d beat=%0d, required 0 0 3 0",
               dut.r_state, dut.r_grant, dut.r_last, dut.r_beat);
    end
    cyc();
    m_stb = '0; fml_ack = 1'b0;
    cyc();
    sys_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    m_stb = 4'b0100; m_we[2] = 1'b1; m_adr[2*AW +: AW] = 30'h100;
    at_neg();
    checks++;
    if (fml_stb !== 1'b0) begin
      errors++; $display("FAIL single_latency: fml_stb=%b in request cycle, required 0", fml_stb);
    end
    cyc();
    at_neg();
    checks++;
    if (fml_stb !== 1'b1 || fml_adr !== 30'h100 || fml_we !== 1'b1 || fml_sel !== 8'hF2) begin
      errors++;
      $display("FAIL single_cmd: stb=%b adr=%h we=%b sel=%h, required 1 100 1 f2", fml_stb, fml_adr, fml_we, fml_sel);
    end
    for (int c = 2; c <= 4; c++) begin
      cyc(); at_neg();
      checks++;
      if (m_ack !== 4'b0) begin
        errors++; $display("FAIL single_noack: cycle %0d m_ack=%b, required 0000", c, m_ack);
      end
    end
    cyc();
    fml_ack = 1'b1;
    at_neg();
    checks++;
    if (m_ack !== 4'b0100) begin
      errors++; $display("FAIL single_ack: m_ack=%b, required 0100", m_ack);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin fml_ack = 1'b0; m_stb = '0; end
      m_di[2*64 +: 64] = 64'hD0 + 64'(k);
      at_neg();
      checks++;
      if (fml_di !== 64'hD0 + 64'(k) || fml_stb !== 1'b0 || m_ack !== 4'b0) begin
        errors++;
        $display("FAIL single_beat: beat %0d fml_di=%h stb=%b m_ack=%b, required %h 0 0000",
                 k, fml_di, fml_stb, m_ack, 64'hD0 + 64'(k));
      end
    end
    cyc();
    at_neg();
    checks++;
    if (dut.r_state !== ST_IDLE) begin
      errors++; $display("FAIL single_idle: state=%0d on cycle 10, required %0d", dut.r_state, ST_IDLE);
    end
    m_we[2] = 1'b0;
    cyc();
  endtask

  task automatic test_all_four();
    int who;
    int base [NM];
    sys_rst_n = 1'b0; m_stb = 4'hF;
    cyc();
    sys_rst_n = 1'b1;
    for (int i = 0; i < NM; i++) base[i] = ack_cnt[i];
    for (int i = 0; i < NM; i++) begin
      serve(1'b1, who);
      checks++;
      if (who !== i) begin
        errors++; $display("FAIL all_four_order: burst %0d granted master %0d, required %0d", i, who, i);
      end
    end
    cyc();
    for (int i = 0; i < NM; i++) begin
      checks++;
      if (ack_cnt[i] - base[i] !== 1) begin
        errors++; $display("FAIL all_four_count: master %0d got %0d acks, required 1", i, ack_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_alternate();
    int who;
    int exp_who [4] = '{1, 3, 1, 3};
    sys_rst_n = 1'b0; m_stb = 4'b1010;
    cyc();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, who);
      checks++;
      if (who !== exp_who[i]) begin
        errors++; $display("FAIL alternate_order: burst %0d granted %0d, required %0d", i, who, exp_who[i]);
      end
    end
    m_stb = '0;
    cyc(); cyc();
  endtask

  task automatic test_ack_ignored();
    fml_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      checks++;
      if (m_ack !== 4'b0 || dut.r_state !== ST_IDLE) begin
        errors++; $display("FAIL ack_idle: m_ack=%b state=%0d, required 0000 %0d", m_ack, dut.r_state, ST_IDLE);
      end
      cyc();
    end
    m_stb = 4'b0001;
    cyc();
    at_neg();
    checks++;
    if (m_ack !== 4'b0001) begin
      errors++; $display("FAIL ack_grant: m_ack=%b, required 0001", m_ack);
    end
    cyc();
    m_stb = '0;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      checks++;
      if (m_ack !== 4'b0 || dut.r_state !== ST_DATA || dut.r_beat !== 2'(k)) begin
        errors++;
        $display("FAIL ack_data: beat %0d m_ack=%b state=%0d r_beat=%0d, required 0000 %0d %0d",
                 k, m_ack, dut.r_state, dut.r_beat, ST_DATA, k);
      end
      cyc();
    end
    fml_ack = 1'b0;
    at_neg();
    checks++;
    if (dut.r_state !== ST_IDLE) begin
      errors++; $display("FAIL ack_data_exit: state=%0d, required %0d", dut.r_state, ST_IDLE);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int who;
    m_stb = 4'b0010;
    cyc();
    fml_ack = 1'b1;
    cyc();
    fml_ack = 1'b0; m_stb = '0;
    cyc();
    sys_rst_n = 1'b0;
    cyc();
    sys_rst_n = 1'b1; m_stb = 4'b1000;
    at_neg();
    checks++;
    if (fml_stb !== 1'b0 || m_ack !== 4'b0 || dut.r_state !== ST_IDLE || dut.r_last !== 2'd3) begin
      errors++;
      $display("FAIL reset_mid: stb=%b m_ack=%b state=%0d last=%0d, required 0 0000 %0d 3",
               fml_stb, m_ack, dut.r_state, dut.r_last, ST_IDLE);
    end
    serve(1'b1, who);
    checks++;
    if (who !== 3) begin
      errors++; $display("FAIL reset_mid_grant: granted %0d, required 3", who);
    end
    cyc();
  endtask

  task automatic test_stb_drop();
    int who;
    m_stb = 4'b0100;
    cyc();
    at_neg();
    checks++;
    if (fml_stb !== 1'b1) begin
      errors++; $display("FAIL drop_grant: fml_stb=%b, required 1", fml_stb);
    end
    cyc();
    m_stb = 4'b0000;
    at_neg();
    checks++;
    if (fml_stb !== 1'b0 || dut.r_state !== ST_GRANT || dut.r_grant !== 2'd2) begin
      errors++;
      $display("FAIL drop_hold: stb=%b state=%0d grant=%0d, required 0 %0d 2", fml_stb, dut.r_state, dut.r_grant, ST_GRANT);
    end
    cyc();
    m_stb = 4'b0001;
    at_neg();
    checks++;
    if (dut.r_grant !== 2'd2 || fml_stb !== 1'b0) begin
      errors++; $display("FAIL drop_no_rearb: grant=%0d stb=%b, required 2 0", dut.r_grant, fml_stb);
    end
    cyc();
    m_stb = 4'b0101;
    serve(1'b1, who);
    checks++;
    if (who !== 2) begin
      errors++; $display("FAIL drop_resume: granted %0d, required 2", who);
    end
    serve(1'b1, who);
    checks++;
    if (who !== 0) begin
      errors++; $display("FAIL drop_next: granted %0d, required 0", who);
    end
    cyc();
  endtask

  task automatic test_read();
    m_stb = 4'b0001; m_we[0] = 1'b0; fml_do = 64'h1234;
    at_neg();
    checks++;
    if (m_do !== 64'h1234) begin
      errors++; $display("FAIL read_pass_idle: m_do=%h, required 1234", m_do);
    end
    cyc();
    at_neg();
    checks++;
    if (fml_stb !== 1'b1 || fml_we !== 1'b0 || fml_adr !== 30'h1000) begin
      errors++; $display("FAIL read_cmd: stb=%b we=%b adr=%h, required 1 0 1000", fml_stb, fml_we, fml_adr);
    end
    cyc();
    fml_ack = 1'b1;
    cyc();
    fml_ack = 1'b0; m_stb = '0;
    for (int k = 0; k < 4; k++) begin
      fml_do = 64'hA5 + 64'(k);
      at_neg();
      checks++;
      if (m_do !== 64'hA5 + 64'(k)) begin
        errors++; $display("FAIL read_beat: beat %0d m_do=%h, required %h", k, m_do, 64'hA5 + 64'(k));
      end
      cyc();
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_ack_ignored();
    test_reset_mid();
    test_stb_drop();
    test_read();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++; $display("FAIL ack_overlap: %0d cycles with multiple m_ack bits, required 0", overlap_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
